// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (I) and
// load/store (D): one outstanding transaction, ack timeout with sticky bus error.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              bus_err
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t              state, state_nx;
  logic                last_d, last_d_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                m_req_nx, m_we_nx, bus_err_nx;
  logic [3:0]          m_be_nx;
  logic [ADDR_W-1:0]   m_addr_nx;
  logic [DATA_W-1:0]   m_wdata_nx;
  logic                grant_d;
  logic                finish;
  logic [DATA_W-1:0]   rdata_c;

  // D wins a tie unless it was the last port served.
  assign grant_d = d_req && (!i_req || !last_d);
  // A real ack on the last allowed cycle wins over the timeout.
  assign finish  = m_ack || (cnt == CNT_LAST);
  assign rdata_c = m_ack ? m_rdata : '0;

  always_comb begin
    state_nx   = state;
    last_d_nx  = last_d;
    cnt_nx     = cnt;
    m_req_nx   = m_req;
    m_we_nx    = m_we;
    m_be_nx    = m_be;
    m_addr_nx  = m_addr;
    m_wdata_nx = m_wdata;
    bus_err_nx = bus_err;
    i_ack      = 1'b0;
    d_ack      = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nx   = BUSY_D;
          last_d_nx  = 1'b1;
          cnt_nx     = '0;
          m_req_nx   = 1'b1;
          m_we_nx    = d_we;
          m_be_nx    = d_be;
          m_addr_nx  = d_addr;
          m_wdata_nx = d_wdata;
        end else if (i_req) begin
          state_nx   = BUSY_I;
          last_d_nx  = 1'b0;
          cnt_nx     = '0;
          m_req_nx   = 1'b1;
          m_we_nx    = 1'b0;
          m_be_nx    = 4'b1111;
          m_addr_nx  = i_addr;
          m_wdata_nx = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (finish) begin
          // A transaction cut short by reset is never acknowledged.
          i_ack      = (state == BUSY_I) && !rst;
          d_ack      = (state == BUSY_D) && !rst;
          i_rdata    = (state == BUSY_I) ? rdata_c : '0;
          d_rdata    = (state == BUSY_D) ? rdata_c : '0;
          bus_err_nx = bus_err || !m_ack;
          state_nx   = IDLE;
          m_req_nx   = 1'b0;
          cnt_nx     = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      cnt     <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_be    <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_nx;
      last_d  <= last_d_nx;
      cnt     <= cnt_nx;
      m_req   <= m_req_nx;
      m_we    <= m_we_nx;
      m_be    <= m_be_nx;
      m_addr  <= m_addr_nx;
      m_wdata <= m_wdata_nx;
      bus_err <= bus_err_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed timing cases plus randomized traffic
// against a memory responder and a reference memory kept in the bench.
module tb_mem_arbiter;

  localparam int TO = 16;

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    bit is_d;
    int c;
  } ack_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ack, d_ack;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  logic        bus_err;

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;

  exp_t iq[$];
  exp_t dq[$];
  ack_t ack_log[$];

  logic [31:0] dmem   [logic [31:0]];
  logic [31:0] refmem [logic [31:0]];

  int mem_lat = 0;
  bit mem_rand = 1'b0;
  bit mem_noack = 1'b0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return refmem.exists(a) ? refmem[a] : memfn(a);
  endfunction

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : memfn(a);
  endfunction

  function automatic exp_t mk(input logic [31:0] rd, input int c);
    exp_t e;
    e.rdata = rd;
    e.cyc   = c;
    return e;
  endfunction

  // Memory responder: acks L cycles after m_req rises, returns the pre-write word.
  int bcnt = 0;
  int cur_lat = 0;
  always @(posedge clk) begin
    #1;
    m_ack   = 1'b0;
    m_rdata = $urandom;
    if (m_req) begin
      if (bcnt == 0) cur_lat = mem_rand ? int'($urandom_range(0, 4)) : mem_lat;
      if (!mem_noack && bcnt == cur_lat) begin
        m_ack   = 1'b1;
        m_rdata = dev_read(m_addr);
        if (m_we) dmem[m_addr] = merge(dev_read(m_addr), m_wdata, m_be);
      end
      bcnt++;
    end else begin
      bcnt = 0;
    end
  end

  // Grant checker: every new memory request must carry the fields of the port
  // that round-robin arbitration over the previous cycle's requests selects.
  bit last_was_d = 1'b0;
  bit pi = 1'b0, pd = 1'b0, pm = 1'b0;
  always @(negedge clk) begin
    bit win_d;
    if (rst) begin
      last_was_d = 1'b0;
      pi = 1'b0; pd = 1'b0; pm = 1'b0;
    end else begin
      if (m_req && !pm) begin
        chk("grant_without_request", 96'(pi || pd), 96'(1));
        win_d = pd && (!pi || !last_was_d);
        if (win_d)
          chk("grant_fields_d", 96'({m_we, m_be, m_addr, m_wdata}),
              96'({d_we, d_be, d_addr, d_wdata}));
        else
          chk("grant_fields_i", 96'({m_we, m_be, m_addr, m_wdata}),
              96'({1'b0, 4'hF, i_addr, 32'h0}));
        last_was_d = win_d;
      end
      pi = i_req; pd = d_req; pm = m_req;
    end
  end

  // Monitor: pops the expected response of whichever port acks.
  always @(negedge clk) begin
    exp_t e;
    ack_t a;
    if (i_ack || d_ack) chk("ack_overlap", 96'(i_ack && d_ack), 96'(0));
    if (i_ack) begin
      if (iq.size() == 0) chk("unexpected_i_ack", 96'(1), 96'(0));
      else begin
        e = iq.pop_front();
        chk("i_rdata", 96'(i_rdata), 96'(e.rdata));
        if (e.cyc >= 0) chk("i_ack_cycle", 96'(cyc), 96'(e.cyc));
      end
      a.is_d = 1'b0; a.c = cyc; ack_log.push_back(a);
    end
    if (d_ack) begin
      if (dq.size() == 0) chk("unexpected_d_ack", 96'(1), 96'(0));
      else begin
        e = dq.pop_front();
        chk("d_rdata", 96'(d_rdata), 96'(e.rdata));
        if (e.cyc >= 0) chk("d_ack_cycle", 96'(cyc), 96'(e.cyc));
      end
      a.is_d = 1'b1; a.c = cyc; ack_log.push_back(a);
    end
  end

  // Issue one request in the current cycle and hold it until acked; returns at
  // the start of the cycle after the ack with req still high.
  task automatic xact(input bit is_d, input bit we, input logic [3:0] be,
                      input logic [31:0] a, input logic [31:0] wd, input int lat);
    logic [31:0] old;
    int          ec;
    bit          got;
    old = ref_read(a);
    ec  = (lat >= 0) ? cyc + 1 + lat : -1;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_be = be; d_addr = a; d_wdata = wd;
      if (we) refmem[a] = merge(old, wd, be);
      dq.push_back(mk(old, ec));
    end else begin
      i_req = 1'b1; i_addr = a;
      iq.push_back(mk(old, ec));
    end
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = is_d ? d_ack : i_ack;
    end
    chk(is_d ? "d_ack_wait" : "i_ack_wait", 96'(got), 96'(1));
    tick();
  endtask

  task automatic port_rand(input bit is_d, input int n);
    for (int k = 0; k < n; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
        repeat (gap) tick();
      end
      if (is_d)
        xact(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
             32'h1000_0000 + 32'($urandom_range(0, 15)) * 4, $urandom, -1);
      else
        xact(1'b0, 1'b0, 4'hF, 32'h0000_2000 + 32'($urandom_range(0, 63)) * 4, 32'h0, -1);
    end
    if (is_d) d_req = 1'b0; else i_req = 1'b0;
  endtask

  initial begin
    int  n0;
    bit  got;
    refmem[32'h10] = 32'h0050_0113;
    dmem[32'h10]   = 32'h0050_0113;

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_m_req", 96'(m_req), 96'(0));
    chk("rst_m_we", 96'(m_we), 96'(0));
    chk("rst_m_be", 96'(m_be), 96'(0));
    chk("rst_m_addr", 96'(m_addr), 96'(0));
    chk("rst_m_wdata", 96'(m_wdata), 96'(0));
    chk("rst_i_ack", 96'(i_ack), 96'(0));
    chk("rst_d_ack", 96'(d_ack), 96'(0));
    chk("rst_bus_err", 96'(bus_err), 96'(0));
    tick();
    rst = 1'b0;

    // I-only fetch, zero-latency memory
    mem_lat = 0;
    n0 = cyc;
    i_req = 1'b1; i_addr = 32'h10;
    iq.push_back(mk(32'h0050_0113, n0 + 1));
    @(negedge clk);
    chk("fetch_m_req_before", 96'(m_req), 96'(0));
    @(negedge clk);
    chk("fetch_m_req", 96'(m_req), 96'(1));
    chk("fetch_m_we", 96'(m_we), 96'(0));
    chk("fetch_m_be", 96'(m_be), 96'(4'hF));
    chk("fetch_i_ack", 96'(i_ack), 96'(1));
    tick();
    i_req = 1'b0;
    @(negedge clk);
    chk("fetch_m_req_after", 96'(m_req), 96'(0));
    tick();

    // D store, L=3
    mem_lat = 3;
    n0 = cyc;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    dq.push_back(mk(ref_read(32'h100), n0 + 4));
    refmem[32'h100] = merge(ref_read(32'h100), 32'hDEAD_BEEF, 4'b0011);
    @(negedge clk);
    @(negedge clk);
    chk("store_m_we", 96'(m_we), 96'(1));
    chk("store_m_be", 96'(m_be), 96'(4'h3));
    chk("store_m_wdata", 96'(m_wdata), 96'(32'hDEAD_BEEF));
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = d_ack;
    end
    chk("store_ack_seen", 96'(got), 96'(1));
    tick();
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // Both ports continuously requesting from reset, L=1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_lat = 1;
    ack_log.delete();
    fork
      begin
        for (int k = 0; k < 2; k++) xact(1'b1, 1'b0, 4'hF, 32'h1000_0000 + 32'(k * 4), 32'h0, -1);
        d_req = 1'b0;
      end
      begin
        for (int k = 0; k < 2; k++) xact(1'b0, 1'b0, 4'hF, 32'h0000_2000 + 32'(k * 4), 32'h0, -1);
        i_req = 1'b0;
      end
    join
    chk("rr_ack_count", 96'(ack_log.size()), 96'(4));
    if (ack_log.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("rr_order", 96'(ack_log[k].is_d), 96'(k % 2 == 0));
        if (k > 0) chk("rr_spacing", 96'(ack_log[k].c - ack_log[k-1].c), 96'(3));
      end
    end
    tick();

    // m_ack on the last allowed cycle is a normal completion
    mem_lat = TO - 1;
    xact(1'b0, 1'b0, 4'hF, 32'h0000_2080, 32'h0, TO - 1);
    i_req = 1'b0;
    @(negedge clk);
    chk("edge_ack_bus_err", 96'(bus_err), 96'(0));
    tick();

    // Memory never acks: timeout
    mem_noack = 1'b1;
    n0 = cyc;
    i_req = 1'b1; i_addr = 32'h0000_20C0;
    iq.push_back(mk(32'h0, n0 + TO));
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = i_ack;
    end
    chk("timeout_ack_seen", 96'(got), 96'(1));
    chk("timeout_bus_err_during", 96'(bus_err), 96'(0));
    tick();
    i_req = 1'b0;
    @(negedge clk);
    chk("timeout_bus_err_after", 96'(bus_err), 96'(1));
    mem_noack = 1'b0;
    mem_lat = 2;
    tick();
    xact(1'b0, 1'b0, 4'hF, 32'h0000_2100, 32'h0, 2);
    i_req = 1'b0;
    @(negedge clk);
    chk("bus_err_sticky", 96'(bus_err), 96'(1));
    tick();

    // Reset in the second BUSY_D cycle aborts without an ack
    mem_lat = 5;
    n0 = cyc;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1000_0040; d_wdata = 32'h0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dq.push_back(mk(ref_read(32'h1000_0040), n0 + 9));
    @(negedge clk);
    chk("abort_m_req", 96'(m_req), 96'(0));
    chk("abort_bus_err", 96'(bus_err), 96'(0));
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = d_ack;
    end
    chk("abort_retry_ack", 96'(got), 96'(1));
    tick();
    d_req = 1'b0;
    tick();

    // Randomized traffic on both ports with random latency
    mem_rand = 1'b1;
    fork
      port_rand(1'b1, 40);
      port_rand(1'b0, 40);
    join
    repeat (10) tick();
    chk("drain_iq", 96'(iq.size()), 96'(0));
    chk("drain_dq", 96'(dq.size()), 96'(0));
    chk("final_bus_err", 96'(bus_err), 96'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified memory port of the `cpu` core between instruction fetch (I-port) and load/store (D-port). It serialises requests with a round-robin grant and presents one outstanding transaction at a time to memory. A timeout guards against a memory that never acknowledges. It sits between the fetch/LSU logic inside `cpu` and the memory model driven by the testbench.

## Interface
- `ADDR_W`, 32: address width in bits.
- `DATA_W`, 32: data width in bits; must be 32, because byte enables are 4 bits.
- `TIMEOUT`, 16: maximum cycles to wait for `m_ack` before aborting; must be at least 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: fetch request, level, held until `i_ack`.
- `i_addr` in ADDR_W: fetch address.
- `i_rdata` out DATA_W: fetch data, valid only while `i_ack`=1.
- `i_ack` out 1: one-cycle completion pulse.
- `d_req` in 1: load/store request, level, held until `d_ack`.
- `d_we` in 1: 1 = store.
- `d_be` in 4: byte enables.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_rdata` out DATA_W: load data, valid only while `d_ack`=1.
- `d_ack` out 1: one-cycle completion pulse.
- `m_req` out 1: memory request, held until `m_ack` or timeout.
- `m_we` out 1: memory write enable.
- `m_be` out 4: memory byte enables.
- `m_addr` out ADDR_W: memory address.
- `m_wdata` out DATA_W: memory write data.
- `m_rdata` in DATA_W: memory read data, valid with `m_ack`.
- `m_ack` in 1: memory completion, a one-cycle pulse, ignored while `m_req`=0.
- `bus_err` out 1: sticky timeout flag; cleared only by `rst`.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- In IDLE, arbitration uses the current cycle's `i_req`/`d_req`:
  - Neither asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the port not granted last, tracked in a one-bit `last_d` register. After reset `last_d`=0, so D wins the first tie.
- On grant:
  - Register `m_addr`, `m_we`, `m_be` and `m_wdata` from the winner.
  - For the I-port: `m_we`=0, `m_be`=4'b1111, `m_wdata`=0.
  - Set `m_req`=1, update `last_d`, and enter BUSY_I or BUSY_D.
- In BUSY_x with `m_ack`=1:
  - `x_ack`=1 combinationally in the same cycle.
  - `x_rdata`=`m_rdata`.
  - Next edge: `m_req`=0, timeout counter cleared, return to IDLE.
- The ungranted port's ack is always 0. Its rdata is don't-care and is driven 0 in the model.
- Timeout:
  - An `ADDR_W`-independent counter, ceil(log2(TIMEOUT+1)) bits, increments each BUSY cycle without `m_ack`.
  - When it equals TIMEOUT-1 and `m_ack`=0: pulse `x_ack`=1 with `x_rdata`=0, set `bus_err`=1, then `m_req`=0 and return to IDLE.
  - A store that times out is considered lost.
- An `m_ack` arriving in the same cycle the counter hits TIMEOUT-1 counts as success: normal ack, `bus_err` unchanged.
- Requester rules:
  - Requesters must keep req/addr/data stable from assertion through ack.
  - Dropping req before ack is illegal; the arbiter ignores it and completes the transaction anyway.
  - Req still high in the cycle after ack is treated as a new request.
- `rst` in any state: next edge forces IDLE, `last_d`=0, counter=0. No ack is issued for the aborted transaction.

## Timing
- Reset values: `m_req`=0, `m_we`=0, `m_be`=0, `m_addr`=0, `m_wdata`=0, `i_ack`=0, `d_ack`=0, `bus_err`=0, state=IDLE.
- Request seen in IDLE at cycle N: `m_req`=1 from cycle N+1.
- Memory acking L cycles after `m_req` rises (L≥0): `x_ack` in cycle N+1+L.
- Minimum round trip: 2 cycles (N+1, with `m_ack` in the first `m_req` cycle).
- Back-to-back throughput: one transaction per L+2 cycles, because IDLE always costs one cycle.
- With both ports continuously requesting, grants alternate D, I, D, I…
- Timeout with no ack: `x_ack` pulses in cycle N+TIMEOUT, and `bus_err` is high from N+TIMEOUT+1.

## Test plan
- Reset, then I-only: `i_addr`=0x10, memory returns 0x00500113 with L=0. Require `m_req` high cycle 1, `i_ack`+`i_rdata`=0x00500113 cycle 1, `m_req` low cycle 2, `m_we`=0, `m_be`=4'hF.
- D store: `d_addr`=0x100, `d_wdata`=0xDEADBEEF, `d_be`=4'b0011, L=3. Require `m_we`=1, `m_be`=0x3, `m_wdata`=0xDEADBEEF, and `d_ack` exactly 4 cycles after the request is sampled.
- Both requesting continuously from reset, L=1. Require grant order D, I, D, I; each ack 3 cycles apart; `i_ack` and `d_ack` never high together.
- Memory never acks, TIMEOUT=16, I request at cycle 0. Require `i_ack`=1 with `i_rdata`=0 at cycle 16, `bus_err`=1 from cycle 17 and staying 1 over later successful transactions until `rst`.
- `rst` asserted at BUSY_D cycle 2 (L=5). Require `m_req`=0 and IDLE next edge, no `d_ack` ever. After release with `d_req` still high, a fresh transaction completes normally.
- `m_ack` coincident with counter=TIMEOUT-1. Require a normal ack carrying `m_rdata` and `bus_err` remaining 0.
